interrupt_source_controller: RTL
================================

Name: interrupt_source_controller

Overview:
- Source side of the control unit's interrupt interface.
- Synchronises external interrupt request lines, edge-detects them and latches pending bits.
- Arbitrates by fixed priority and drives InterruptIn/InterruptHandler into the multicycle control FSM.
- Consumes the control unit's EPCWrite (acknowledge), CLR (pending clear) and RetFromInt (handler exit) to sequence service; one interrupt in service at a time, no nesting.

Parameters:
- NUM_SRC, 4, number of request lines; also width of InterruptHandler, CLR, mask and pending vectors.
- SYNC_STAGES, 2, flip-flop stages in each request-line synchroniser (minimum 2).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IrqReq  input  NUM_SRC  asynchronous external request lines; rising edge = event.
- MaskWrite  input  1  load IrqMask from MaskData this cycle.
- MaskData  input  NUM_SRC  new mask value; 1 = source disabled.
- EPCWrite  input  1  from control unit; acknowledges the presented interrupt.
- CLR  input  NUM_SRC  from control unit; one-hot/multi-hot clear of pending bits.
- RetFromInt  input  1  from control unit; handler finished.
- InterruptIn  output  1  interrupt request to control unit.
- InterruptHandler  output  NUM_SRC  one-hot granted source, stable while InterruptIn=1 and in SERVICE.
- Pending  output  NUM_SRC  pending register, unmasked view.
- IrqMask  output  NUM_SRC  current mask register.
- InService  output  1  high in SERVICE state.

Behaviour:
- Reset (RST_N=0, async): sync chains, edge-detect history, Pending, IrqMask, InterruptHandler all 0; InterruptIn=0; InService=0; FSM=IDLE. Reset mid-request or mid-service abandons it; no pending bit survives.
- Sync/edge: IrqReq[i] passes SYNC_STAGES flops. Pending[i] sets on a synchronised 0->1 transition. Edge to Pending visible = SYNC_STAGES+1 rising edges. A level held high sets pending only once.
- Clear: Pending[i] clears when CLR[i]=1, in any state. Simultaneous set edge and CLR on the same bit: set wins, so no event is lost.
- Mask: MaskWrite loads IrqMask next edge. Masked sources still latch pending but are not eligible. eligible = Pending & ~IrqMask.
- Priority: highest index wins (bit NUM_SRC-1 highest).
- FSM states:
  - IDLE: InterruptIn=0. If eligible != 0, latch one-hot of highest eligible bit into InterruptHandler and go to REQUEST. InterruptIn=1 from the next cycle; total edge-to-InterruptIn latency is SYNC_STAGES+2 cycles.
  - REQUEST: InterruptIn=1 and InterruptHandler frozen. Later arrivals, mask changes or a CLR of the granted bit do not withdraw or re-arbitrate. On EPCWrite=1 go to SERVICE; InterruptIn=0 from the next cycle.
  - SERVICE: InService=1, InterruptIn=0, InterruptHandler held. New events only set Pending. On RetFromInt=1 go to IDLE, zero InterruptHandler, and arbitrate again on the following cycle.
- Stray inputs: EPCWrite in IDLE/SERVICE ignored; RetFromInt in IDLE/REQUEST ignored.
- Handler responsibility: the handler must CLR its own bit. If it does not, the same source re-requests after return.

Test Plan:
- Reset behaviour: RST_N low mid-REQUEST, with IrqReq=4'b0100 and InterruptIn=1 → InterruptIn, Pending, InterruptHandler and InService are all 0 immediately, without waiting for a clock edge.
- Basic request and handshake: IrqReq 4'b0000→4'b0010 with NUM_SRC=4, SYNC_STAGES=2 → Pending=4'b0010 after 3 edges; InterruptIn=1 and InterruptHandler=4'b0010 one cycle later. Pulse EPCWrite → InService=1, InterruptIn=0. Then CLR=4'b0010 plus RetFromInt → Pending=0 and FSM returns to IDLE.
- Priority and hold: raise bits 0 and 3 together → InterruptHandler=4'b1000. Raising bit 2 during REQUEST leaves InterruptHandler at 4'b1000. After service with CLR=4'b1000, the next grant is 4'b0100, then 4'b0001.
- Mask: MaskWrite with MaskData=4'b0001, then edge on bit 0 → Pending=4'b0001 and InterruptIn stays 0. Write mask 4'b0000 → InterruptIn=1 with handler 4'b0001.
- Set/clear collision: synchronised edge on bit 1 in the same cycle as CLR=4'b0010 → Pending[1]=1 afterwards. A level held high for 20 cycles produces exactly one request.

Source files
------------

// File: rtl/interrupt_source_controller.sv
// Interrupt source side: synchronises request lines, latches edge events as pending bits,
// and grants the highest-index unmasked pending source to the control unit one at a time.
// Edge to InterruptIn is SYNC_STAGES+2 cycles. Service is sequenced by EPCWrite, CLR and RetFromInt.
module interrupt_source_controller #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IrqReq,
  input  logic               MaskWrite,
  input  logic [NUM_SRC-1:0] MaskData,
  input  logic               EPCWrite,
  input  logic [NUM_SRC-1:0] CLR,
  input  logic               RetFromInt,
  output logic               InterruptIn,
  output logic [NUM_SRC-1:0] InterruptHandler,
  output logic [NUM_SRC-1:0] Pending,
  output logic [NUM_SRC-1:0] IrqMask,
  output logic               InService
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Stage 0 is the flop fed directly by the pin; the last stage is the settled value.
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] r_sync;
  logic [NUM_SRC-1:0]                  r_sync_d;
  logic [NUM_SRC-1:0]                  r_pending;
  logic [NUM_SRC-1:0]                  r_mask;
  logic [NUM_SRC-1:0]                  r_handler;
  logic [NUM_SRC-1:0]                  w_handler_nxt;
  logic [NUM_SRC-1:0]                  w_rise;
  logic [NUM_SRC-1:0]                  w_eligible;
  logic [NUM_SRC-1:0]                  w_grant;

  // Shift each request line through its synchroniser and keep one cycle of history for edge detect.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync   <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], IrqReq};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
  assign w_eligible = r_pending & ~r_mask;

  // Pending bits: a fresh edge overrides a same-cycle clear so no event is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~CLR) | w_rise;
    end
  end

  // Mask register, loaded on request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mask <= '0;
    end else if (MaskWrite) begin
      r_mask <= MaskData;
    end
  end

  // Fixed priority: ascending scan so the highest eligible index is the one left standing.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_eligible[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
      end
    end
  end

  // State and granted-source registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_handler <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_handler <= w_handler_nxt;
    end
  end

  // Next state and handler; the grant is frozen from REQUEST until return so nothing re-arbitrates mid-service.
  always_comb begin
    w_state_nxt   = r_state;
    w_handler_nxt = r_handler;
    case (r_state)
      ST_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt   = ST_REQUEST;
          w_handler_nxt = w_grant;
        end
      end
      ST_REQUEST: begin
        if (EPCWrite) begin
          w_state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (RetFromInt) begin
          w_state_nxt   = ST_IDLE;
          w_handler_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_handler_nxt = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state so they fall immediately on async reset.
  always_comb begin
    InterruptIn = (r_state == ST_REQUEST);
    InService   = (r_state == ST_SERVICE);
  end

  assign InterruptHandler = r_handler;
  assign Pending          = r_pending;
  assign IrqMask          = r_mask;

endmodule
